// File: rtl/hazard_unit.sv
// Hazard detection FSM: load-use and ID-resolved branch stalls, redirect squash.
// Optional perf counters when HAZARD_PERF_EN is defined.
module hazard_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       branch,
  input  logic       jump,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_reg_we,
  input  logic       id_ex_mem_read,
  input  logic [4:0] ex_mem_rd,
  input  logic       ex_mem_reg_we,
  input  logic       ex_mem_mem_read,
  input  logic       redirect,
`ifdef HAZARD_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_ex_bubble,
  output logic       if_id_flush,
  output logic       hz_busy
);

  typedef enum logic {RUN, STALL} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] need;
  logic       br;
  logic       m_ex;
  logic       m_mem;
  logic       stall;

  assign br = branch | jump;

  // x0 is hardwired zero, so it never carries a real dependence
  assign m_ex = id_ex_reg_we && (id_ex_rd != 5'd0) &&
    ((id_use_rs1 && id_ex_rd == id_rs1) ||
     (id_use_rs2 && id_ex_rd == id_rs2));

  assign m_mem = ex_mem_reg_we && (ex_mem_rd != 5'd0) &&
    ((id_use_rs1 && ex_mem_rd == id_rs1) ||
     (id_use_rs2 && ex_mem_rd == id_rs2));

  always_comb begin
    need = 2'd0;
    if (br && id_ex_mem_read && m_ex)
      need = 2'd2;
    else if (br && m_ex)
      need = 2'd1;
    else if (br && ex_mem_mem_read && m_mem)
      need = 2'd1;
    else if (!br && id_ex_mem_read && m_ex)
      need = 2'd1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        cnt_d = 2'd0;
        if (need != 2'd0) begin
          stall   = 1'b1;
          cnt_d   = need - 2'd1;
          state_d = (need > 2'd1) ? STALL : RUN;
        end
      end
      STALL: begin
        stall = 1'b1;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1)
          state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low combinationally so reset takes effect at once
  assign pc_stall     = !rst && stall;
  assign if_id_stall  = !rst && stall;
  assign id_ex_bubble = !rst && stall;
  assign if_id_flush  = !rst && redirect && !stall;
  assign hz_busy      = !rst && (state_q == STALL);

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (pc_stall)
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (if_id_flush)
        flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; outputs checked as a 5-bit vector
// {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, hz_busy}.
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2;
  logic       id_use_rs1, id_use_rs2;
  logic       branch, jump;
  logic [4:0] id_ex_rd;
  logic       id_ex_reg_we, id_ex_mem_read;
  logic [4:0] ex_mem_rd;
  logic       ex_mem_reg_we, ex_mem_mem_read;
  logic       redirect;
  logic       pc_stall, if_id_stall, id_ex_bubble;
  logic       if_id_flush, hz_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [4:0] got;

  hazard_unit dut (
    .clk(clk),
    .rst(rst),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .branch(branch),
    .jump(jump),
    .id_ex_rd(id_ex_rd),
    .id_ex_reg_we(id_ex_reg_we),
    .id_ex_mem_read(id_ex_mem_read),
    .ex_mem_rd(ex_mem_rd),
    .ex_mem_reg_we(ex_mem_reg_we),
    .ex_mem_mem_read(ex_mem_mem_read),
    .redirect(redirect),
`ifdef HAZARD_PERF_EN
    .stall_cycles(stall_cycles),
    .flush_count(flush_count),
`endif
    .pc_stall(pc_stall),
    .if_id_stall(if_id_stall),
    .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush),
    .hz_busy(hz_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got = {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, hz_busy};

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    branch = 0; jump = 0;
    id_ex_rd = 0; id_ex_reg_we = 0; id_ex_mem_read = 0;
    ex_mem_rd = 0; ex_mem_reg_we = 0; ex_mem_mem_read = 0;
    redirect = 0;
  endtask

  // Advance to the next falling edge so new inputs settle between rising edges
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    id_ex_rd = 5; id_ex_reg_we = 1; id_ex_mem_read = 1;
    id_rs1 = 5; id_use_rs1 = 1; redirect = 1;
    repeat (2) @(posedge clk);
    next_cycle(); #1;
    checks++;
    if (got !== 5'b00000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", got, 5'b00000);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cycles !== 0 || flush_count !== 0) begin
      failures++;
      $display("FAIL reset_perf got=%0d/%0d exp=0/0", stall_cycles, flush_count);
    end
`endif
    clear_inputs();
    rst = 1'b0;
    #1;
    checks++;
    if (got !== 5'b00000) begin
      failures++;
      $display("FAIL reset_release_idle got=%b exp=%b", got, 5'b00000);
    end
  endtask

  task automatic test_branch_load();
    next_cycle(); clear_inputs();
    branch = 1; id_rs2 = 7; id_use_rs2 = 1;
    id_ex_rd = 7; id_ex_reg_we = 1; id_ex_mem_read = 1;
    #1;
    checks++;
    if (got !== 5'b11100) begin
      failures++;
      $display("FAIL br_load_c1 got=%b exp=%b", got, 5'b11100);
    end
    next_cycle();
    redirect = 1;
    #1;
    checks++;
    if (got !== 5'b11101) begin
      failures++;
      $display("FAIL br_load_c2 got=%b exp=%b", got, 5'b11101);
    end
    next_cycle(); clear_inputs();
    branch = 1; id_rs2 = 7; id_use_rs2 = 1;
    #1;
    checks++;
    if (got !== 5'b00000) begin
      failures++;
      $display("FAIL br_load_c3 got=%b exp=%b", got, 5'b00000);
    end
  endtask

  task automatic test_branch_alu();
    next_cycle(); clear_inputs();
    branch = 1; id_rs1 = 3; id_use_rs1 = 1;
    id_ex_rd = 3; id_ex_reg_we = 1;
    redirect = 1;
    #1;
    checks++;
    if (got !== 5'b11100) begin
      failures++;
      $display("FAIL br_alu_c1 got=%b exp=%b", got, 5'b11100);
    end
    next_cycle(); clear_inputs();
    branch = 1; id_rs1 = 3; id_use_rs1 = 1;
    ex_mem_rd = 3; ex_mem_reg_we = 1;
    redirect = 1;
    #1;
    checks++;
    if (got !== 5'b00010) begin
      failures++;
      $display("FAIL br_alu_c2 got=%b exp=%b", got, 5'b00010);
    end
    next_cycle(); clear_inputs();
    #1;
    checks++;
    if (got !== 5'b00000) begin
      failures++;
      $display("FAIL br_alu_c3 got=%b exp=%b", got, 5'b00000);
    end
  endtask

  task automatic test_perf();
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cycles !== 32'd3) begin
      failures++;
      $display("FAIL perf_stall_cycles got=%0d exp=3", stall_cycles);
    end
    checks++;
    if (flush_count !== 32'd1) begin
      failures++;
      $display("FAIL perf_flush_count got=%0d exp=1", flush_count);
    end
`endif
  endtask

  task automatic test_load_use();
    next_cycle(); clear_inputs();
    id_ex_rd = 5; id_ex_reg_we = 1; id_ex_mem_read = 1;
    id_rs1 = 5; id_use_rs1 = 1;
    #1;
    checks++;
    if (got !== 5'b11100) begin
      failures++;
      $display("FAIL load_use_c1 got=%b exp=%b", got, 5'b11100);
    end
    next_cycle(); clear_inputs();
    id_rs1 = 5; id_use_rs1 = 1;
    ex_mem_rd = 5; ex_mem_reg_we = 1; ex_mem_mem_read = 1;
    #1;
    checks++;
    if (got !== 5'b00000) begin
      failures++;
      $display("FAIL load_use_c2 got=%b exp=%b", got, 5'b00000);
    end
  endtask

  task automatic test_back_to_back();
    next_cycle(); clear_inputs();
    id_ex_rd = 4; id_ex_reg_we = 1; id_ex_mem_read = 1;
    id_rs2 = 4; id_use_rs2 = 1;
    #1;
    checks++;
    if (got !== 5'b11100) begin
      failures++;
      $display("FAIL b2b_c1 got=%b exp=%b", got, 5'b11100);
    end
    next_cycle(); clear_inputs();
    id_ex_rd = 6; id_ex_reg_we = 1; id_ex_mem_read = 1;
    id_rs1 = 6; id_use_rs1 = 1;
    #1;
    checks++;
    if (got !== 5'b11100) begin
      failures++;
      $display("FAIL b2b_c2 got=%b exp=%b", got, 5'b11100);
    end
  endtask

  task automatic test_mem_load_jump();
    next_cycle(); clear_inputs();
    jump = 1; id_rs1 = 9; id_use_rs1 = 1;
    ex_mem_rd = 9; ex_mem_reg_we = 1; ex_mem_mem_read = 1;
    #1;
    checks++;
    if (got !== 5'b11100) begin
      failures++;
      $display("FAIL mem_load_jump got=%b exp=%b", got, 5'b11100);
    end
    next_cycle(); clear_inputs();
    id_rs1 = 9; id_use_rs1 = 1;
    ex_mem_rd = 9; ex_mem_reg_we = 1; ex_mem_mem_read = 1;
    #1;
    checks++;
    if (got !== 5'b00000) begin
      failures++;
      $display("FAIL mem_load_nobranch got=%b exp=%b", got, 5'b00000);
    end
  endtask

  task automatic test_x0_and_flags();
    next_cycle(); clear_inputs();
    id_ex_rd = 0; id_ex_reg_we = 1; id_ex_mem_read = 1;
    id_rs1 = 0; id_use_rs1 = 1; branch = 1;
    #1;
    checks++;
    if (got !== 5'b00000) begin
      failures++;
      $display("FAIL x0_no_stall got=%b exp=%b", got, 5'b00000);
    end
    next_cycle(); clear_inputs();
    id_ex_rd = 5; id_ex_reg_we = 1; id_ex_mem_read = 1;
    id_rs1 = 5; id_use_rs1 = 0;
    #1;
    checks++;
    if (got !== 5'b00000) begin
      failures++;
      $display("FAIL unused_src got=%b exp=%b", got, 5'b00000);
    end
    next_cycle(); clear_inputs();
    id_ex_rd = 5; id_ex_reg_we = 0; id_ex_mem_read = 1;
    id_rs1 = 5; id_use_rs1 = 1; redirect = 1;
    #1;
    checks++;
    if (got !== 5'b00010) begin
      failures++;
      $display("FAIL no_we_redirect got=%b exp=%b", got, 5'b00010);
    end
  endtask

  task automatic test_reset_mid_stall();
    next_cycle(); clear_inputs();
    branch = 1; id_rs1 = 8; id_use_rs1 = 1;
    id_ex_rd = 8; id_ex_reg_we = 1; id_ex_mem_read = 1;
    next_cycle();
    #1;
    checks++;
    if (got !== 5'b11101) begin
      failures++;
      $display("FAIL mid_stall_busy got=%b exp=%b", got, 5'b11101);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (got !== 5'b00000) begin
      failures++;
      $display("FAIL mid_stall_async got=%b exp=%b", got, 5'b00000);
    end
    next_cycle(); clear_inputs();
    rst = 1'b0;
    next_cycle();
    #1;
    checks++;
    if (got !== 5'b00000) begin
      failures++;
      $display("FAIL after_reset_idle got=%b exp=%b", got, 5'b00000);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_branch_load();
    test_branch_alu();
    test_perf();
    test_load_use();
    test_back_to_back();
    test_mem_load_jump();
    test_x0_and_flags();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
